// File: rtl/vga_pkg.sv
// vga_pkg: timing-set type, stock video modes and raster total helpers
package vga_pkg;
    localparam int CW = 11;
    typedef struct packed {
        logic [CW-1:0] h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp;
    } timing_t;
    localparam timing_t MODE_640x480 = '{11'd640, 11'd16, 11'd96, 11'd48, 11'd480, 11'd10, 11'd2, 11'd33};
    localparam timing_t MODE_800x600 = '{11'd800, 11'd40, 11'd128, 11'd88, 11'd600, 11'd1, 11'd4, 11'd23};
    function automatic logic [CW-1:0] total_h(timing_t m);
        return m.h_active + m.h_fp + m.h_sync + m.h_bp;
    endfunction
    function automatic logic [CW-1:0] total_v(timing_t m);
        return m.v_active + m.v_fp + m.v_sync + m.v_bp;
    endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: valid/ready request port carrying a new timing set
interface vga_timing_gen_if;
    import vga_pkg::*;
    timing_t mode;
    logic    vld;
    logic    rdy;
    modport master (output mode, vld, input rdy);
    modport slave  (input mode, vld, output rdy);
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: pe-gated shift register lining sync flags up with the pixel pipeline
module vga_delay_line #(
    parameter int           W     = 3,
    parameter int           DEPTH = 0,
    parameter logic [W-1:0] RST   = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    localparam int N = DEPTH > 0 ? DEPTH : 1;
    logic [W-1:0] sr [N];
    always_ff @(posedge clk)
        if (rst) sr <= '{default: RST};
        else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
        end
    assign q = (DEPTH == 0) ? d : sr[N-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: runtime-reconfigurable raster timing generator;
// new modes wait in a one-deep slot and are committed only on the frame wrap.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int      CW       = vga_pkg::CW,
    parameter int      PIX_DIV  = 1,
    parameter logic    H_POL    = 1'b0,
    parameter logic    V_POL    = 1'b0,
    parameter int      SYNC_DLY = 0,
    parameter timing_t DEFAULT  = MODE_640x480
) (
    input  logic            clk,
    input  logic            rst,
    vga_timing_gen_if.slave req,
    output logic            pe,
    output logic [CW-1:0]   x,
    output logic [CW-1:0]   y,
    output logic            hs,
    output logic            vs,
    output logic            de,
    output logic            hs_d,
    output logic            vs_d,
    output logic            de_d,
    output logic            ls,
    output logic            of,
    output timing_t         cur_mode
);
    timing_t       slot, nm;
    logic          full, commit, last_x, last_y, pe_n, hs_n, vs_n, de_n;
    logic [3:0]    div;
    logic [CW-1:0] x_n, y_n, h_lo, v_lo;
    always_comb begin
        pe_n   = div == 4'(PIX_DIV - 1);
        last_x = x == total_h(cur_mode) - CW'(1);
        last_y = y == total_v(cur_mode) - CW'(1);
        ls     = pe && last_x;
        of     = ls && last_y;
        commit = of && full;
        nm     = commit ? slot : cur_mode;
        x_n    = !pe ? x : last_x ? '0 : x + CW'(1);
        y_n    = !ls ? y : last_y ? '0 : y + CW'(1);
        h_lo   = nm.h_active + nm.h_fp;
        v_lo   = nm.v_active + nm.v_fp;
        // flags come from the next coordinates so they line up with x/y
        de_n   = x_n < nm.h_active && y_n < nm.v_active;
        hs_n   = (x_n >= h_lo && x_n < h_lo + nm.h_sync) ? H_POL : !H_POL;
        vs_n   = (y_n >= v_lo && y_n < v_lo + nm.v_sync) ? V_POL : !V_POL;
    end
    assign req.rdy = !full;
    always_ff @(posedge clk)
        if (rst) begin
            div      <= '0;
            pe       <= 1'b0;
            x        <= '0;
            y        <= '0;
            de       <= 1'b1;
            hs       <= !H_POL;
            vs       <= !V_POL;
            full     <= 1'b0;
            slot     <= DEFAULT;
            cur_mode <= DEFAULT;
        end else begin
            div <= pe_n ? '0 : div + 4'd1;
            pe  <= pe_n;
            x   <= x_n;
            y   <= y_n;
            de  <= de_n;
            hs  <= hs_n;
            vs  <= vs_n;
            // a request landing on the wrap clock sees an empty slot and waits a frame
            if (commit) begin
                cur_mode <= slot;
                full     <= 1'b0;
            end else if (req.vld && !full) begin
                slot <= req.mode;
                full <= 1'b1;
            end
        end
    vga_delay_line #(.W(3), .DEPTH(SYNC_DLY), .RST({!H_POL, !V_POL, 1'b0})) u_dly (
        .clk(clk), .rst(rst), .en(pe), .d({hs, vs, de}), .q({hs_d, vs_d, de_d})
    );
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generator configurations; frame wraps are scored from an expectation queue
module tb_vga_timing_gen;
    import vga_pkg::*;
    localparam timing_t M1 = '{11'd8, 11'd2, 11'd3, 11'd4, 11'd4, 11'd1, 11'd2, 11'd3};
    localparam timing_t M2 = '{11'd6, 11'd1, 11'd1, 11'd2, 11'd3, 11'd1, 11'd1, 11'd1};
    typedef struct { timing_t m; int per; int dec; } exp_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    exp_t sb[$];
    logic rst_a = 1'b1, rst_b = 1'b1, rst_s = 1'b1;
    logic pe_a, hs_a, vs_a, de_a, hsd_a, vsd_a, ded_a, ls_a, of_a;
    logic pe_b, hs_b, vs_b, de_b, hsd_b, vsd_b, ded_b, ls_b, of_b;
    logic pe_s, hs_s, vs_s, de_s, hsd_s, vsd_s, ded_s, ls_s, of_s;
    logic [10:0] x_a, y_a, x_b, y_b, x_s, y_s;
    timing_t cur_a, cur_b, cur_s;
    vga_timing_gen_if if_a();
    vga_timing_gen_if if_b();
    vga_timing_gen_if if_s();
    vga_timing_gen u_a (.clk(clk), .rst(rst_a), .req(if_a), .pe(pe_a), .x(x_a), .y(y_a), .hs(hs_a), .vs(vs_a),
        .de(de_a), .hs_d(hsd_a), .vs_d(vsd_a), .de_d(ded_a), .ls(ls_a), .of(of_a), .cur_mode(cur_a));
    vga_timing_gen #(.PIX_DIV(3), .H_POL(1'b1), .SYNC_DLY(4), .DEFAULT(M1)) u_b (.clk(clk), .rst(rst_b), .req(if_b),
        .pe(pe_b), .x(x_b), .y(y_b), .hs(hs_b), .vs(vs_b), .de(de_b), .hs_d(hsd_b), .vs_d(vsd_b), .de_d(ded_b),
        .ls(ls_b), .of(of_b), .cur_mode(cur_b));
    vga_timing_gen #(.DEFAULT(M1)) u_s (.clk(clk), .rst(rst_s), .req(if_s), .pe(pe_s), .x(x_s), .y(y_s),
        .hs(hs_s), .vs(vs_s), .de(de_s), .hs_d(hsd_s), .vs_d(vsd_s), .de_d(ded_s), .ls(ls_s), .of(of_s),
        .cur_mode(cur_s));

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic wait_of_s(string name);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (of_s) return;
        end
        timeout(name);
    endtask

    task automatic wait_xy_s(int wx, int wy, string name);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (x_s == 11'(wx) && y_s == 11'(wy)) return;
        end
        timeout(name);
    endtask

    task automatic req_s(timing_t m, string name);
        assert (int'(total_h(m)) == int'(m.h_active) + int'(m.h_fp) + int'(m.h_sync) + int'(m.h_bp));
        chk({name, "_rdy_before"}, if_s.rdy, 1);
        if_s.vld  = 1'b1;
        if_s.mode = m;
        @(negedge clk);
        if_s.vld  = 1'b0;
        chk({name, "_rdy_after"}, if_s.rdy, 0);
    endtask

    // monitor: every frame wrap of u_s pops one expectation (mode after wrap, clocks per frame, de pixels)
    initial begin : monitor
        int clk_cnt, de_cnt;
        logic chk_next;
        exp_t e;
        clk_cnt = 0; de_cnt = 0; chk_next = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_s) begin
                clk_cnt = 0; de_cnt = 0; chk_next = 1'b0;
            end else begin
                if (chk_next) chk("sb_mode", cur_s, e.m);
                chk_next = 1'b0;
                clk_cnt++;
                if (pe_s && de_s) de_cnt++;
                if (of_s) begin
                    if (sb.size() == 0) timeout("sb_unexpected_of");
                    else begin
                        e = sb.pop_front();
                        if (e.per >= 0) chk("sb_period", clk_cnt, e.per);
                        chk("sb_de_count", de_cnt, e.dec);
                        chk_next = 1'b1;
                    end
                    clk_cnt = 0; de_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        if_a.vld = 1'b0; if_a.mode = '0;
        if_b.vld = 1'b0; if_b.mode = '0;
        if_s.vld = 1'b0; if_s.mode = '0;
        repeat (3) @(negedge clk);
        // ---- 640x480, PIX_DIV=1 ----
        chk("a_rst_x", x_a, 0);  chk("a_rst_y", y_a, 0);  chk("a_rst_de", de_a, 1);
        chk("a_rst_hs", hs_a, 1); chk("a_rst_vs", vs_a, 1); chk("a_rst_hsd", hsd_a, 1);
        chk("a_rst_vsd", vsd_a, 1); chk("a_rst_pe", pe_a, 0); chk("a_rst_ls", ls_a, 0);
        chk("a_rst_of", of_a, 0); chk("a_rst_rdy", if_a.rdy, 1); chk("a_rst_mode", cur_a, MODE_640x480);
        rst_a = 1'b0;
        begin : a_lines
            int n_pe, n_hs, hs_min, hs_max, n_de, n_ls, ls_bad, n_of;
            n_pe = 0; n_hs = 0; hs_min = 4095; hs_max = -1; n_de = 0; n_ls = 0; ls_bad = 0; n_of = 0;
            for (int i = 0; i < 1600; i++) begin
                @(negedge clk);
                n_pe += int'(pe_a);
                n_de += int'(de_a);
                n_of += int'(of_a);
                if (!hs_a) begin
                    n_hs++;
                    if (int'(x_a) < hs_min) hs_min = int'(x_a);
                    if (int'(x_a) > hs_max) hs_max = int'(x_a);
                end
                if (ls_a) begin
                    n_ls++;
                    if (x_a != 11'd799) ls_bad++;
                end
            end
            chk("a_pe_count", n_pe, 1600); chk("a_hs_low_count", n_hs, 192);
            chk("a_hs_first_x", hs_min, 656); chk("a_hs_last_x", hs_max, 751);
            chk("a_de_count", n_de, 1280); chk("a_ls_count", n_ls, 2);
            chk("a_ls_at_799", ls_bad, 0); chk("a_no_of", n_of, 0);
            @(negedge clk);
            chk("a_wrap_x", x_a, 0); chk("a_wrap_y", y_a, 2);
        end
        // ---- PIX_DIV=3, H_POL=1, SYNC_DLY=4 on the small mode ----
        chk("b_rst_hs", hs_b, 0); chk("b_rst_hsd", hsd_b, 0); chk("b_rst_vs", vs_b, 1);
        chk("b_rst_vsd", vsd_b, 1); chk("b_rst_de", de_b, 1); chk("b_rst_ded", ded_b, 0);
        chk("b_rst_pe", pe_b, 0);
        rst_b = 1'b0;
        begin : b_run
            int k, first_pe, bad_xy, bad_hsd, bad_ded, n_of, of0, of1, n_ls, ls_nope, n_hi, hi_min, hi_max;
            logic e_hsd, e_ded;
            k = 0; first_pe = -1; bad_xy = 0; bad_hsd = 0; bad_ded = 0; n_of = 0; of0 = -1; of1 = -1;
            n_ls = 0; ls_nope = 0; n_hi = 0; hi_min = 4095; hi_max = -1;
            for (int i = 1; i <= 1100; i++) begin
                @(negedge clk);
                if (ls_b && !pe_b) ls_nope++;
                if (ls_b) n_ls++;
                if (of_b) begin
                    if (n_of == 0) of0 = i;
                    if (n_of == 1) of1 = i;
                    n_of++;
                end
                if (pe_b) begin
                    if (first_pe < 0) first_pe = i;
                    if (int'(x_b) != k % 17 || int'(y_b) != (k / 17) % 10) bad_xy++;
                    e_hsd = k >= 4 && (k - 4) % 17 >= 10 && (k - 4) % 17 <= 12;
                    e_ded = k >= 4 && (k - 4) % 17 < 8 && ((k - 4) / 17) % 10 < 4;
                    if (hsd_b !== e_hsd) bad_hsd++;
                    if (ded_b !== e_ded) bad_ded++;
                    if (hs_b) begin
                        n_hi++;
                        if (int'(x_b) < hi_min) hi_min = int'(x_b);
                        if (int'(x_b) > hi_max) hi_max = int'(x_b);
                    end
                    k++;
                end
            end
            chk("b_first_pe", first_pe, 3); chk("b_pe_count", k, 366); chk("b_xy_track", bad_xy, 0);
            chk("b_hsd_delay", bad_hsd, 0); chk("b_ded_delay", bad_ded, 0);
            chk("b_of_count", n_of, 2); chk("b_of_first", of0, 510); chk("b_frame_period", of1 - of0, 510);
            chk("b_ls_count", n_ls, 21); chk("b_ls_width", ls_nope, 0);
            chk("b_hs_high_count", n_hi, 63); chk("b_hs_first_x", hi_min, 10); chk("b_hs_last_x", hi_max, 12);
        end
        // ---- mode handshake and commit on the small default mode ----
        sb.push_back('{M1, -1, 32});
        sb.push_back('{M1, 170, 32});
        rst_s = 1'b0;
        wait_of_s("s_f1");
        begin : s_frame2
            int n_hs, n_vs, n_ls, hx0, hx1, vy0, vy1;
            n_hs = 0; n_vs = 0; n_ls = 0; hx0 = 4095; hx1 = -1; vy0 = 4095; vy1 = -1;
            for (int i = 0; i < 170; i++) begin
                @(negedge clk);
                n_ls += int'(ls_s);
                if (!hs_s) begin
                    n_hs++;
                    if (int'(x_s) < hx0) hx0 = int'(x_s);
                    if (int'(x_s) > hx1) hx1 = int'(x_s);
                end
                if (!vs_s) begin
                    n_vs++;
                    if (int'(y_s) < vy0) vy0 = int'(y_s);
                    if (int'(y_s) > vy1) vy1 = int'(y_s);
                end
            end
            chk("s_f2_of_on_time", of_s, 1); chk("s_hs_low_count", n_hs, 30); chk("s_vs_low_count", n_vs, 34);
            chk("s_hs_first_x", hx0, 10); chk("s_hs_last_x", hx1, 12);
            chk("s_vs_first_y", vy0, 5); chk("s_vs_last_y", vy1, 6); chk("s_ls_count", n_ls, 10);
        end
        sb.push_back('{M2, 170, 32});
        wait_xy_s(0, 3, "s_wait_f3");
        req_s(M2, "s_req_m2");
        chk("s_no_early_commit", cur_s, M1);
        wait_of_s("s_f3");
        chk("s_rdy_low_at_of", if_s.rdy, 0);
        @(negedge clk);
        chk("s_rdy_after_commit", if_s.rdy, 1); chk("s_mode_m2", cur_s, M2);
        sb.push_back('{M1, 60, 18});
        sb.push_back('{M1, 170, 32});
        wait_xy_s(0, 1, "s_wait_f4");
        req_s(M1, "s_req_m1");
        if_s.vld = 1'b1; if_s.mode = MODE_800x600;
        repeat (5) @(negedge clk);
        chk("s_second_req_blocked", if_s.rdy, 0);
        if_s.vld = 1'b0;
        wait_of_s("s_f4");
        @(negedge clk);
        chk("s_pending_not_overwritten", cur_s, M1);
        wait_of_s("s_f5");
        sb.push_back('{M2, 170, 32});
        req_s(M2, "s_req_on_of");
        chk("s_of_req_no_bypass", cur_s, M1); chk("s_of_wrap_x", x_s, 0); chk("s_of_wrap_y", y_s, 0);
        wait_of_s("s_f6");
        @(negedge clk);
        chk("s_of_req_commit_next", cur_s, M2);
        sb.push_back('{MODE_800x600, 60, 18});
        wait_xy_s(0, 2, "s_wait_f7");
        req_s(MODE_800x600, "s_req_800");
        wait_of_s("s_f7");
        begin : s_line
            int n;
            n = 0;
            for (int i = 0; i < 3000 && !(n > 0 && ls_s); i++) begin
                @(negedge clk);
                n++;
            end
            chk("s_800_line_clks", n, 1056); chk("s_800_ls_x", x_s, 1055);
        end
        req_s(M2, "s_req_pending");
        wait_xy_s(300, 2, "s_wait_reset_point");
        rst_s = 1'b1;
        @(negedge clk);
        chk("s_rst_x", x_s, 0); chk("s_rst_y", y_s, 0); chk("s_rst_de", de_s, 1);
        chk("s_rst_hs", hs_s, 1); chk("s_rst_vs", vs_s, 1); chk("s_rst_rdy", if_s.rdy, 1);
        chk("s_rst_mode", cur_s, M1); chk("s_rst_pe", pe_s, 0);
        rst_s = 1'b0;
        sb.push_back('{M1, -1, 32});
        wait_of_s("s_after_rst");
        @(negedge clk);
        chk("s_no_stale_commit", cur_s, M1);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
